// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and its forwarding units.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic             valid;
        logic             wen;
        logic             is_load;
        logic [REG_W-1:0] dest;
    } stage_t;

    // A stage produces the operand only if it holds a live instruction that writes
    // a non-zero register matching the source.
    function automatic logic stage_match(input stage_t s, input logic [REG_W-1:0] src,
                                         input logic use_src);
        return use_src & s.valid & s.wen & (s.dest == src) & (src != '0);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding select and load-use detection for the ID stage.
module fwd_sel_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  stage_t           exe,
    input  stage_t           mem,
    input  stage_t           wb,
    output logic [1:0]       sel,
    output logic             load_use
);

    logic m_exe;
    logic m_mem;
    logic m_wb;

    assign m_exe = stage_match(exe, src, use_src);
    assign m_mem = stage_match(mem, src, use_src);
    assign m_wb  = stage_match(wb,  src, use_src);

    // Youngest producer wins; a load in EXE cannot forward yet, so ID stalls instead.
    always_comb begin
        sel      = FWD_RF;
        load_use = m_exe & exe.is_load;
        if (m_exe) begin
            sel = exe.is_load ? FWD_RF : FWD_EXE;
        end else if (m_mem) begin
            sel = FWD_MEM;
        end else if (m_wb) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage valid bits, allowin handshake, register
// enables, load-use stall, ID forwarding selects and a stall performance counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             exe_busy,
    output logic             inst_req,
    output logic             pc_en,
    output logic             if2id_en,
    output logic             id2exe_en,
    output logic             exe2mem_en,
    output logic             mem2wb_en,
    output logic             id_valid,
    output logic             exe_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             rf_wen_gate,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_t     exe_s;
    stage_t     mem_s;
    stage_t     wb_s;
    logic       fs_valid;

    logic       load_use_rs;
    logic       load_use_rt;
    logic       load_use;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;

    logic       wb_allowin;
    logic       mem_allowin;
    logic       exe_ready;
    logic       exe_allowin;
    logic       id_ready;
    logic       id_allowin;
    logic       stall_cond;

    fwd_sel_unit u_fwd_rs (
        .src      (id_rs),
        .use_src  (id_use_rs),
        .exe      (exe_s),
        .mem      (mem_s),
        .wb       (wb_s),
        .sel      (rs_sel),
        .load_use (load_use_rs)
    );

    fwd_sel_unit u_fwd_rt (
        .src      (id_rt),
        .use_src  (id_use_rt),
        .exe      (exe_s),
        .mem      (mem_s),
        .wb       (wb_s),
        .sel      (rt_sel),
        .load_use (load_use_rt)
    );

    assign load_use  = load_use_rs | load_use_rt;
    assign exe_valid = exe_s.valid;
    assign mem_valid = mem_s.valid;
    assign wb_valid  = wb_s.valid;

    // Backpressure chain from WB toward fetch; all enables are held off during reset.
    always_comb begin
        wb_allowin  = 1'b1;
        mem_allowin = ~mem_s.valid | wb_allowin;
        exe_ready   = ~exe_busy;
        exe_allowin = ~exe_s.valid | (exe_ready & mem_allowin);
        id_ready    = ~load_use;
        id_allowin  = ~id_valid | (id_ready & exe_allowin);
        stall_cond  = (id_valid & ~id_ready) | (exe_s.valid & exe_busy);

        inst_req    = ~rst;
        pc_en       = ~rst & fs_valid & id_allowin;
        if2id_en    = ~rst & fs_valid & id_allowin;
        id2exe_en   = ~rst & id_valid & id_ready & exe_allowin;
        exe2mem_en  = ~rst & exe_s.valid & exe_ready & mem_allowin;
        mem2wb_en   = ~rst & mem_s.valid;
        rf_wen_gate = ~rst & wb_s.valid & wb_s.wen;
        fwd_rs_sel  = rst ? FWD_RF : rs_sel;
        fwd_rt_sel  = rst ? FWD_RF : rt_sel;
    end

    // Valid bits, destination tracking and the stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fs_valid  <= 1'b0;
            id_valid  <= 1'b0;
            exe_s     <= '0;
            mem_s     <= '0;
            wb_s      <= '0;
            stall_cnt <= '0;
        end else begin
            fs_valid <= 1'b1;
            if (id_allowin) begin
                id_valid <= fs_valid;
            end
            if (exe_allowin) begin
                exe_s.valid <= id_valid & id_ready;
            end
            if (id2exe_en) begin
                exe_s.wen     <= id_wen;
                exe_s.is_load <= id_is_load;
                exe_s.dest    <= id_dest;
            end
            if (mem_allowin) begin
                mem_s.valid <= exe_s.valid & exe_ready;
            end
            if (exe2mem_en) begin
                mem_s.wen     <= exe_s.wen;
                mem_s.is_load <= exe_s.is_load;
                mem_s.dest    <= exe_s.dest;
            end
            wb_s.valid <= mem_s.valid;
            if (mem2wb_en) begin
                wb_s.wen     <= mem_s.wen;
                wb_s.is_load <= mem_s.is_load;
                wb_s.dest    <= mem_s.dest;
            end
            if (stall_cond) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios for pipe_hazard_ctrl; expected values are queued per cycle
// when a scenario is set up and compared on the falling edge of that cycle.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] dest;
        logic       wen;
        logic       ld;
    } instr_t;

    typedef struct {
        int    c;
        int    s;
        int    v;
        string tag;
    } exp_t;

    localparam int S_IDV = 0, S_EXV = 1, S_MEMV = 2, S_WBV = 3, S_IREQ = 4, S_PCEN = 5;
    localparam int S_ID2EX = 6, S_EX2MEM = 7, S_RS = 8, S_RT = 9, S_CNT = 10, S_RFW = 11;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_use_rs, id_use_rt, id_wen, id_is_load, exe_busy;
    logic        inst_req, pc_en, if2id_en, id2exe_en, exe2mem_en, mem2wb_en;
    logic        id_valid, exe_valid, mem_valid, wb_valid, rf_wen_gate;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt;

    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    int     id_idx = -1;
    int     rst_at = -1;
    int     busy_lo = 1;
    int     busy_hi = 0;
    logic   en_q = 1'b0;
    instr_t prog[$];
    exp_t   sb[$];

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_dest     (id_dest),
        .id_wen      (id_wen),
        .id_is_load  (id_is_load),
        .exe_busy    (exe_busy),
        .inst_req    (inst_req),
        .pc_en       (pc_en),
        .if2id_en    (if2id_en),
        .id2exe_en   (id2exe_en),
        .exe2mem_en  (exe2mem_en),
        .mem2wb_en   (mem2wb_en),
        .id_valid    (id_valid),
        .exe_valid   (exe_valid),
        .mem_valid   (mem_valid),
        .wb_valid    (wb_valid),
        .rf_wen_gate (rf_wen_gate),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, obs, exp_v);
    endtask

    function automatic int observe(input int s);
        case (s)
            S_IDV:    return int'(id_valid);
            S_EXV:    return int'(exe_valid);
            S_MEMV:   return int'(mem_valid);
            S_WBV:    return int'(wb_valid);
            S_IREQ:   return int'(inst_req);
            S_PCEN:   return int'(pc_en);
            S_ID2EX:  return int'(id2exe_en);
            S_EX2MEM: return int'(exe2mem_en);
            S_RS:     return int'(fwd_rs_sel);
            S_RT:     return int'(fwd_rt_sel);
            S_CNT:    return int'(stall_cnt);
            S_RFW:    return int'(rf_wen_gate);
            default:  return -1;
        endcase
    endfunction

    function automatic void ex(input int c, input int s, input int v, input string tag);
        exp_t e;
        e.c = c; e.s = s; e.v = v; e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic instr_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                  input int dest, input bit wen, input bit ld);
        instr_t t;
        t.rs = 5'(rs); t.rt = 5'(rt); t.use_rs = urs; t.use_rt = urt;
        t.dest = 5'(dest); t.wen = wen; t.ld = ld;
        return t;
    endfunction

    // Scoreboard: compare every queued expectation that falls due in this cycle.
    always @(negedge clk) begin
        en_q = if2id_en;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c == cyc) begin
                chk(sb[i].tag, observe(sb[i].s), sb[i].v);
                sb.delete(i);
            end
        end
    end

    task automatic drive_id();
        instr_t t;
        t = mk(0, 0, 0, 0, 0, 0, 0);
        if (id_idx >= 0 && id_idx < prog.size()) t = prog[id_idx];
        id_rs = t.rs; id_rt = t.rt; id_use_rs = t.use_rs; id_use_rt = t.use_rt;
        id_dest = t.dest; id_wen = t.wen; id_is_load = t.ld;
    endtask

    // One clock: IF/ID advances in the bench when the DUT enabled it last cycle.
    task automatic tick();
        @(posedge clk); #1;
        if (en_q) id_idx++;
        if (cyc == rst_at) rst = 1'b1;
        exe_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        drive_id();
    endtask

    task automatic start_scen(output int r);
        @(posedge clk); #1;
        rst = 1'b1; id_idx = -1; rst_at = -1; busy_lo = 1; busy_hi = 0; exe_busy = 1'b0;
        drive_id();
        r = cyc + 3;
    endtask

    task automatic release_rst();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r;
        rst = 1'b1; exe_busy = 1'b0;
        drive_id();

        // Reset release and pipeline fill with bubbles-free NOPs
        prog.delete();
        start_scen(r);
        ex(r-1, S_IDV, 0, "rst_idv");   ex(r-1, S_EXV, 0, "rst_exv");
        ex(r-1, S_MEMV, 0, "rst_memv"); ex(r-1, S_WBV, 0, "rst_wbv");
        ex(r-1, S_IREQ, 0, "rst_ireq"); ex(r-1, S_PCEN, 0, "rst_pcen");
        ex(r-1, S_CNT, 0, "rst_cnt");   ex(r-1, S_RS, 0, "rst_rs");
        ex(r,   S_IREQ, 1, "rel_ireq"); ex(r,   S_PCEN, 0, "rel_pcen0"); ex(r, S_IDV, 0, "rel_idv0");
        ex(r+1, S_PCEN, 1, "rel_pcen1"); ex(r+1, S_IDV, 0, "rel_idv1");
        ex(r+2, S_IDV, 1, "fill_idv");  ex(r+2, S_EXV, 0, "fill_exv0");
        ex(r+3, S_EXV, 1, "fill_exv");  ex(r+3, S_MEMV, 0, "fill_memv0");
        ex(r+4, S_MEMV, 1, "fill_memv"); ex(r+4, S_WBV, 0, "fill_wbv0");
        ex(r+5, S_WBV, 1, "fill_wbv");  ex(r+5, S_RFW, 0, "fill_rfw_nop");
        release_rst();
        run_until(r+6);

        // Dependent ALU chain: EXE/MEM/WB forwarding and youngest-wins priority
        prog.delete();
        prog.push_back(mk(1, 2, 1, 1, 3, 1, 0));
        prog.push_back(mk(3, 3, 1, 1, 3, 1, 0));
        prog.push_back(mk(3, 0, 1, 1, 7, 1, 0));
        prog.push_back(mk(3, 7, 1, 1, 8, 1, 0));
        prog.push_back(mk(7, 3, 1, 1, 9, 1, 0));
        start_scen(r);
        ex(r+2, S_RS, 0, "alu_rs_none"); ex(r+2, S_RT, 0, "alu_rt_none");
        ex(r+3, S_RS, 1, "alu_rs_exe");  ex(r+3, S_RT, 1, "alu_rt_exe");
        ex(r+3, S_PCEN, 1, "alu_pcen");  ex(r+3, S_ID2EX, 1, "alu_id2ex");
        ex(r+4, S_RS, 1, "alu_rs_exe_over_mem"); ex(r+4, S_RT, 0, "alu_rt_r0");
        ex(r+5, S_RS, 2, "alu_rs_mem_over_wb");  ex(r+5, S_RT, 1, "alu_rt_exe2");
        ex(r+5, S_RFW, 1, "alu_rfw");
        ex(r+6, S_RS, 2, "alu_rs_mem");  ex(r+6, S_RT, 3, "alu_rt_wb");
        ex(r+7, S_CNT, 0, "alu_cnt");
        release_rst();
        run_until(r+8);

        // Load-use: one stall cycle, one bubble, then MEM forwarding
        prog.delete();
        prog.push_back(mk(1, 0, 1, 0, 5, 1, 1));
        prog.push_back(mk(5, 0, 1, 1, 6, 1, 0));
        start_scen(r);
        ex(r+2, S_PCEN, 1, "lu_pcen_pre");
        ex(r+3, S_PCEN, 0, "lu_pcen_stall"); ex(r+3, S_ID2EX, 0, "lu_id2ex_stall");
        ex(r+3, S_EXV, 1, "lu_exv_load");    ex(r+3, S_IDV, 1, "lu_idv_held");
        ex(r+4, S_EXV, 0, "lu_bubble");      ex(r+4, S_RS, 2, "lu_rs_mem");
        ex(r+4, S_PCEN, 1, "lu_pcen_resume"); ex(r+4, S_CNT, 1, "lu_cnt");
        ex(r+4, S_MEMV, 1, "lu_memv_load");
        ex(r+5, S_EXV, 1, "lu_exv_user");    ex(r+6, S_CNT, 1, "lu_cnt_once");
        release_rst();
        run_until(r+7);

        // Multicycle EXE busy for four cycles
        prog.delete();
        prog.push_back(mk(0, 0, 0, 0, 10, 1, 0));
        prog.push_back(mk(10, 0, 1, 0, 11, 1, 0));
        prog.push_back(mk(11, 0, 1, 0, 12, 1, 0));
        prog.push_back(mk(12, 11, 1, 1, 13, 1, 0));
        prog.push_back(mk(13, 0, 1, 0, 14, 1, 0));
        start_scen(r);
        ex(r+4, S_PCEN, 0, "busy_pcen0"); ex(r+4, S_EX2MEM, 0, "busy_e2m0");
        ex(r+4, S_MEMV, 1, "busy_memv_old"); ex(r+4, S_RS, 1, "busy_rs_exe");
        ex(r+5, S_PCEN, 0, "busy_pcen1"); ex(r+5, S_EX2MEM, 0, "busy_e2m1");
        ex(r+5, S_MEMV, 0, "busy_memv1"); ex(r+5, S_CNT, 1, "busy_cnt1");
        ex(r+6, S_PCEN, 0, "busy_pcen2"); ex(r+6, S_MEMV, 0, "busy_memv2");
        ex(r+7, S_PCEN, 0, "busy_pcen3"); ex(r+7, S_EX2MEM, 0, "busy_e2m3");
        ex(r+7, S_MEMV, 0, "busy_memv3"); ex(r+7, S_CNT, 3, "busy_cnt3");
        ex(r+8, S_PCEN, 1, "busy_pcen_resume"); ex(r+8, S_EX2MEM, 1, "busy_e2m_resume");
        ex(r+8, S_MEMV, 0, "busy_memv4"); ex(r+8, S_CNT, 4, "busy_cnt4");
        ex(r+8, S_RS, 1, "busy_rs_held"); ex(r+8, S_EXV, 1, "busy_exv");
        ex(r+9, S_MEMV, 1, "busy_memv_back"); ex(r+9, S_CNT, 4, "busy_cnt_final");
        ex(r+9, S_RS, 1, "busy_rs_next"); ex(r+9, S_RT, 2, "busy_rt_mem");
        ex(r+10, S_RS, 1, "busy_rs_after");
        busy_lo = r + 4; busy_hi = r + 7;
        release_rst();
        run_until(r+11);

        // Register 0 writer never forwards or stalls
        prog.delete();
        prog.push_back(mk(1, 2, 1, 1, 0, 1, 0));
        prog.push_back(mk(0, 0, 1, 1, 4, 1, 0));
        prog.push_back(mk(0, 0, 1, 1, 5, 1, 0));
        start_scen(r);
        ex(r+3, S_RS, 0, "r0_rs_exe"); ex(r+3, S_RT, 0, "r0_rt_exe");
        ex(r+3, S_PCEN, 1, "r0_pcen"); ex(r+3, S_ID2EX, 1, "r0_id2ex");
        ex(r+4, S_RS, 0, "r0_rs_mem"); ex(r+4, S_RT, 0, "r0_rt_mem");
        ex(r+5, S_CNT, 0, "r0_cnt");
        release_rst();
        run_until(r+6);

        // Reset asserted during the load-use stall
        prog.delete();
        prog.push_back(mk(1, 0, 1, 0, 5, 1, 1));
        prog.push_back(mk(5, 0, 1, 1, 6, 1, 0));
        start_scen(r);
        ex(r+4, S_IDV, 0, "mr_idv");   ex(r+4, S_EXV, 0, "mr_exv");
        ex(r+4, S_MEMV, 0, "mr_memv"); ex(r+4, S_WBV, 0, "mr_wbv");
        ex(r+4, S_CNT, 0, "mr_cnt");   ex(r+4, S_RS, 0, "mr_rs");
        ex(r+4, S_RT, 0, "mr_rt");     ex(r+4, S_PCEN, 0, "mr_pcen");
        rst_at = r + 3;
        release_rst();
        run_until(r+5);

        tick();
        @(negedge clk); #1;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
